hazard_scoreboard_unit: RTL and testbench
=========================================

# hazard_scoreboard_unit

Parametrised successor to the pipeline's ID-stage hazard detector. It keeps a per-register scoreboard of countdown counters for results still in flight, so stall length follows each producer's result latency: 1 for loads, N for a multi-cycle memory, or longer for a mult/div unit. It also holds `syscall` in ID until every pending write to `$v0` has resolved, and drives the same PC/IR/bubble controls as the existing pipeline plus a stall performance counter.

## Interface
Parameters:
- `NREG`, 32: architectural register count.
- `REG_W`, 5: register index width; `NREG <= 2**REG_W`.
- `LAT_W`, 3: width of a latency value; maximum result latency is `2**LAT_W-1` cycles.
- `CNT_W`, 32: stall performance counter width.

Ports:
- `clk`, input, 1: single clock.
- `rst`, input, 1: reset, asynchronous and active-high.
- `id_valid`, input, 1: ID holds a real instruction.
- `id_rs`, `id_rt`, input, `REG_W` each: source registers.
- `id_use_rs`, `id_use_rt`, input, 1 each: the source is actually read.
- `id_op`, `id_funct`, input, 6 each: opcode and funct, used for `syscall` decode.
- `id_wr_en`, input, 1: the instruction writes a register.
- `id_wr_reg`, input, `REG_W`: destination register.
- `id_wr_lat`, input, `LAT_W`: extra cycles before the result becomes forwardable. 0 = plain ALU op, 1 = load.
- `id_flush`, input, 1: the ID instruction is squashed this cycle (branch/jump).
- `hazard`, output, 1: active-low; 0 inserts a bubble into ID/EX.
- `pc_write`, output, 1: 0 freezes the PC.
- `ir_write`, output, 1: 0 freezes IF/ID.
- `hazard_pc_src`, output, 1: 1 selects the held PC.
- `stall_count`, output, `CNT_W`: cycles stalled since reset, saturating.

## Operation
State:
- `cnt[r]`, `LAT_W` bits, for r = 1..NREG-1. `cnt[0]` is constant 0.
- `ex_wr_v0`, 1 bit.
- `stall_count`.

Stall condition (combinational, from registered state and ID inputs):
- `stall = id_valid & !id_flush & (raw | sys)`.
- `raw`: (`id_use_rs` and `cnt[id_rs]` != 0) or (`id_use_rt` and `cnt[id_rt]` != 0).
- `sys`: `id_op` == 0 and `id_funct` == 6'b001100, and (`cnt[2]` != 0 or `ex_wr_v0`).

Outputs:
- When `stall`: `hazard`=0, `pc_write`=0, `ir_write`=0, `hazard_pc_src`=1.
- Otherwise: `hazard`=1, `pc_write`=1, `ir_write`=1, `hazard_pc_src`=0.

Issue:
- `issue = id_valid & !id_flush & !stall`.

Counter update, per register every cycle:
- Base value: `dec = (cnt[r] != 0) ? cnt[r]-1 : 0`.
- If `issue & id_wr_en & id_wr_reg == r` and r != 0, the next value is `max(dec, id_wr_lat)`. Taking the max keeps WAW ordering safe.
- Otherwise the next value is `dec`.

`$v0` tracking:
- `ex_wr_v0` next = `issue & id_wr_en & id_wr_reg == 2`.
- This holds `syscall` for one cycle even behind a 0-latency ALU write to `$v0`.

Performance counter:
- `stall_count` increments when `stall`.
- It holds at `2**CNT_W-1`.

Boundary rules:
- Writes to r0 are never recorded. A source of r0 never stalls.
- `id_flush` wins over `stall`: no bubble, no scoreboard update, no count.
- A source equal to its own destination checks the old counter before the update.
- Reset mid-stall clears all state immediately; the stall drops asynchronously.

## Timing
- Reset values: every `cnt` = 0, `ex_wr_v0` = 0, `stall_count` = 0. Outputs are therefore `hazard`=1, `pc_write`=1, `ir_write`=1, `hazard_pc_src`=0.
- Stall outputs are valid in the same cycle as the ID inputs. There is no added latency.
- A producer issued at cycle t with latency L stalls a dependent instruction in ID during cycles t+1 .. t+L. The dependent issues at t+L+1.
  - L=1 gives the classic single load-use bubble.
  - L=0 gives no stall; forwarding covers it.
- A `syscall` immediately behind a `$v0` writer of latency L stalls max(L,1) cycles.
- `stall_count` updates on the clock edge after each stall cycle.

## Structure
- Package `hazard_pkg` holds:
  - `OP_SPECIAL` = 6'd0
  - `FUNCT_SYSCALL` = 6'b001100
  - `V0_REG` = 5'd2
  - the `lat_t` typedef (`LAT_W` bits)
- Sub-module `hazard_scoreboard`: the `NREG` counter array with its decrement/max update. It has two read ports (rs, rt) plus a `$v0` read.
- The top level contains the stall logic, `ex_wr_v0`, outputs and the performance counter.

## Test plan
- Reset: assert `rst` mid-stall (`cnt[5]`=3) → outputs go to 1/1/1/0 at once, `stall_count` = 0, and after release r5 does not stall.
- Load-use: load to r8 with L=1 at t, then `add` reading r8 → `hazard`=0 at t+1 only, issue at t+2, `stall_count` = 1.
- Long latency: a write to r9 with L=4, then a consumer of r9 → 4 stall cycles. Repeat with a consumer of r0 after a "write" to r0 → 0 stalls.
- WAW: r3 written with L=5, then r3 with L=1 the next cycle → counter = 4, not 1; a consumer of r3 stalls 4 cycles.
- Syscall: ALU write to `$v0` (L=0), then `syscall` → exactly 1 stall cycle. Load to `$v0` (L=2) then `syscall` → 2 stall cycles.
- Flush and saturation: stall condition with `id_flush`=1 → `hazard`=1, no scoreboard change. `CNT_W`=4 with 20 stalls → `stall_count` = 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and types for the ID-stage hazard scoreboard.
package hazard_pkg;

  localparam int unsigned LAT_W_DEF = 3;

  localparam logic [5:0] OP_SPECIAL    = 6'd0;
  localparam logic [5:0] FUNCT_SYSCALL = 6'b001100;
  localparam logic [4:0] V0_REG        = 5'd2;

  typedef logic [LAT_W_DEF-1:0] lat_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: two source read ports plus a $v0 read,
// with a saturating decrement and max-merge on each new write.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG  = 32,
  parameter int unsigned REG_W = 5,
  parameter int unsigned LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             wr_en_i,
  input  logic [REG_W-1:0] wr_reg_i,
  input  logic [LAT_W-1:0] wr_lat_i,
  output logic [LAT_W-1:0] rs_cnt_c,
  output logic [LAT_W-1:0] rt_cnt_c,
  output logic [LAT_W-1:0] v0_cnt_c
);

  // Slots at and above NREG (and slot 0) stay zero so any index is safe.
  localparam int unsigned NSLOT = 2 ** REG_W;

  logic [LAT_W-1:0] cnt_q [NSLOT];
  logic [LAT_W-1:0] cnt_d [NSLOT];

  always_comb begin
    for (int r = 0; r < int'(NSLOT); r++) begin
      cnt_d[r] = '0;
      if (r != 0 && r < int'(NREG)) begin
        cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
        // Max-merge keeps an older, longer producer visible (WAW).
        if (wr_en_i && wr_reg_i == REG_W'(r) && wr_lat_i > cnt_d[r]) begin
          cnt_d[r] = wr_lat_i;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < int'(NSLOT); r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < int'(NSLOT); r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign rs_cnt_c = cnt_q[rs_i];
  assign rt_cnt_c = cnt_q[rt_i];
  assign v0_cnt_c = cnt_q[REG_W'(V0_REG)];

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: latency-aware RAW stalls, syscall $v0 hold,
// pipeline freeze controls and a saturating stall counter.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NREG  = 32,
  parameter int unsigned REG_W = 5,
  parameter int unsigned LAT_W = 3,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [5:0]       id_op,
  input  logic [5:0]       id_funct,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic [LAT_W-1:0] id_wr_lat,
  input  logic             id_flush,
  output logic             hazard,
  output logic             pc_write,
  output logic             ir_write,
  output logic             hazard_pc_src,
  output logic [CNT_W-1:0] stall_count
);

  logic [LAT_W-1:0] rs_cnt_c, rt_cnt_c, v0_cnt_c;
  logic             raw_c, sys_c, stall_c, issue_c;
  logic             ex_wr_v0_q, ex_wr_v0_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  hazard_scoreboard #(
    .NREG (NREG),
    .REG_W(REG_W),
    .LAT_W(LAT_W)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .rs_i    (id_rs),
    .rt_i    (id_rt),
    .wr_en_i (issue_c & id_wr_en),
    .wr_reg_i(id_wr_reg),
    .wr_lat_i(id_wr_lat),
    .rs_cnt_c(rs_cnt_c),
    .rt_cnt_c(rt_cnt_c),
    .v0_cnt_c(v0_cnt_c)
  );

  // Stall is judged on pre-update counters, so a self-dependent source sees the old value.
  always_comb begin
    raw_c   = (id_use_rs && rs_cnt_c != '0) || (id_use_rt && rt_cnt_c != '0);
    sys_c   = (id_op == OP_SPECIAL) && (id_funct == FUNCT_SYSCALL) &&
              (v0_cnt_c != '0 || ex_wr_v0_q);
    stall_c = id_valid && !id_flush && (raw_c || sys_c);
    issue_c = id_valid && !id_flush && !stall_c;

    ex_wr_v0_d    = issue_c && id_wr_en && (id_wr_reg == REG_W'(V0_REG));
    stall_count_d = stall_count_q;
    if (stall_c && stall_count_q != '1) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_wr_v0_q    <= 1'b0;
      stall_count_q <= '0;
    end else begin
      ex_wr_v0_q    <= ex_wr_v0_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign hazard        = !stall_c;
  assign pc_write      = !stall_c;
  assign ir_write      = !stall_c;
  assign hazard_pc_src = stall_c;
  assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit; a second instance with a 4-bit
// stall counter shares the stimulus to exercise saturation.
module tb_hazard_scoreboard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs, id_use_rt, id_wr_en, id_flush;
  logic [4:0]  id_rs, id_rt, id_wr_reg;
  logic [5:0]  id_op, id_funct;
  logic [2:0]  id_wr_lat;
  logic        hazard, pc_write, ir_write, hazard_pc_src;
  logic [31:0] stall_count;
  logic        s_hazard, s_pc_write, s_ir_write, s_pc_src;
  logic [3:0]  s_stall_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_op(id_op), .id_funct(id_funct),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_wr_lat(id_wr_lat), .id_flush(id_flush),
    .hazard(hazard), .pc_write(pc_write), .ir_write(ir_write),
    .hazard_pc_src(hazard_pc_src), .stall_count(stall_count)
  );

  hazard_scoreboard_unit #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_op(id_op), .id_funct(id_funct),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_wr_lat(id_wr_lat), .id_flush(id_flush),
    .hazard(s_hazard), .pc_write(s_pc_write), .ir_write(s_ir_write),
    .hazard_pc_src(s_pc_src), .stall_count(s_stall_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt, input logic [5:0] funct,
                        input logic we, input logic [4:0] wr, input logic [2:0] lat,
                        input logic fl);
    id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_op = 6'd0; id_funct = funct; id_wr_en = we; id_wr_reg = wr; id_wr_lat = lat;
    id_flush = fl;
  endtask

  task automatic check_ctl(input string tag, input logic exp_stall);
    check({tag, ".hazard"},   32'(hazard),        32'(!exp_stall));
    check({tag, ".pc_write"}, 32'(pc_write),      32'(!exp_stall));
    check({tag, ".ir_write"}, 32'(ir_write),      32'(!exp_stall));
    check({tag, ".pc_src"},   32'(hazard_pc_src), 32'(exp_stall));
    check({tag, ".sat_hz"},   32'(s_hazard),      32'(!exp_stall));
  endtask

  // Producer that must issue without stalling.
  task automatic issue_wr(input string tag, input logic [4:0] wr, input logic [2:0] lat);
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 6'h20, 1'b1, wr, lat, 1'b0);
    @(negedge clk);
    check_ctl(tag, 1'b0);
    @(posedge clk); #1;
  endtask

  // Hold the current ID instruction; expect n stall cycles then one issue cycle.
  task automatic expect_stalls(input string tag, input int n);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      check_ctl(tag, i < n);
      if (i < n) exp_cnt++;
      @(posedge clk); #1;
    end
    check({tag, ".stall_count"}, stall_count, 32'(exp_cnt));
  endtask

  initial begin
    rst = 1'b1;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'h20, 1'b0, 5'd0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_ctl("reset", 1'b0);
    check("reset.stall_count", stall_count, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Load-use with L=1
    issue_wr("ld_r8", 5'd8, 3'd1);
    set_id(1'b1, 5'd8, 1'b1, 5'd1, 1'b1, 6'h20, 1'b1, 5'd10, 3'd0, 1'b0);
    expect_stalls("load_use", 1);

    // Long latency L=4
    issue_wr("mul_r9", 5'd9, 3'd4);
    set_id(1'b1, 5'd1, 1'b0, 5'd9, 1'b1, 6'h20, 1'b1, 5'd10, 3'd0, 1'b0);
    expect_stalls("long_lat", 4);

    // r0 is never tracked
    issue_wr("wr_r0", 5'd0, 3'd7);
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 6'h20, 1'b1, 5'd10, 3'd0, 1'b0);
    expect_stalls("r0_src", 0);

    // WAW: L=5 then L=1 leaves counter at 4
    issue_wr("waw_a", 5'd3, 3'd5);
    issue_wr("waw_b", 5'd3, 3'd1);
    set_id(1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 6'h20, 1'b1, 5'd10, 3'd0, 1'b0);
    expect_stalls("waw", 4);

    // Syscall behind ALU $v0 write, then behind L=2 load
    issue_wr("alu_v0", 5'd2, 3'd0);
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 6'b001100, 1'b0, 5'd0, 3'd0, 1'b0);
    expect_stalls("sys_alu", 1);
    issue_wr("ld_v0", 5'd2, 3'd2);
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 6'b001100, 1'b0, 5'd0, 3'd0, 1'b0);
    expect_stalls("sys_ld", 2);

    // Self-dependent source sees the old counter, then its own write
    issue_wr("wr_r11", 5'd11, 3'd3);
    set_id(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 6'h20, 1'b1, 5'd11, 3'd1, 1'b0);
    expect_stalls("self_dep", 3);
    set_id(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 6'h20, 1'b1, 5'd10, 3'd0, 1'b0);
    expect_stalls("self_use", 1);

    // Flush beats stall and does not record its write
    issue_wr("wr_r12", 5'd12, 3'd6);
    set_id(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 6'h20, 1'b1, 5'd13, 3'd7, 1'b1);
    @(negedge clk);
    check_ctl("flush", 1'b0);
    @(posedge clk); #1;
    set_id(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 6'h20, 1'b1, 5'd10, 3'd0, 1'b0);
    expect_stalls("flush_nowr", 0);
    set_id(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 6'h20, 1'b1, 5'd10, 3'd0, 1'b0);
    expect_stalls("after_flush", 4);

    // 20 stalls in total: the 4-bit counter pins at 15
    check("total.stall_count", stall_count, 32'd20);
    check("sat.stall_count", 32'(s_stall_count), 32'd15);

    // Reset mid-stall drops the stall asynchronously
    issue_wr("wr_r5", 5'd5, 3'd3);
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 6'h20, 1'b1, 5'd10, 3'd0, 1'b0);
    @(negedge clk);
    check_ctl("pre_rst", 1'b1);
    #1 rst = 1'b1;
    #1;
    check_ctl("mid_rst", 1'b0);
    check("mid_rst.stall_count", stall_count, 32'd0);
    check("mid_rst.sat_count", 32'(s_stall_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
    expect_stalls("post_rst", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
